// File: rtl/apb_arb_master_if.sv
// Signal bundle between apb_arb_master, its two requesters and the APB register slave.
// Requester i's fields sit in bit i / slice i of each two-wide request and response vector.
interface apb_arb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_arb_master.sv
// Two-requester round-robin APB master driving SETUP/ACCESS on one shared APB bus.
// Optional ACCESS timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_arb_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_arb_master_if.master    bus,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_e            state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              grant_vld;
    logic              grant_idx;
    logic              grant_write;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    // Handshake: req_valid[i] is held with a stable payload until req_ready[i];
    // req_ready[i] is a single-cycle pulse, only in IDLE, and the payload is
    // taken on that same edge and never sampled again.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (state_q == IDLE && !PRESET) begin
            grant_vld = |bus.req_valid;
            if (bus.req_valid == 2'b11) begin
                grant_idx = ~last_grant_q;
            end else begin
                grant_idx = bus.req_valid[1];
            end
        end
    end

    assign grant_write = grant_idx ? bus.req_write[1] : bus.req_write[0];
    assign grant_addr  = grant_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    assign grant_wdata = grant_idx ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

    assign bus.req_ready = grant_vld ? (2'b01 << grant_idx) : 2'b00;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_q;
    logic             rsp_err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else if (state_q == SETUP) begin
            tmo_q <= '0;
        end else if (state_q == ACCESS) begin
            if (bus.PREADY) begin
                rsp_err_q <= 1'b0;
            end else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                rsp_err_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end
        end
    end

    // The last permitted wait cycle ends the transfer unless PREADY wins it.
    logic tmo_hit;
    assign tmo_hit     = !bus.PREADY && (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
    assign bus.rsp_err = rsp_err_q;
`else
    logic tmo_hit;
    assign tmo_hit     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q      <= grant_idx;
                        last_grant_q <= grant_idx;
                        pwrite_q     <= grant_write;
                        paddr_q      <= grant_addr;
                        pwdata_q     <= grant_wdata;
                        psel_q       <= 1'b1;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY || tmo_hit) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                        rsp_valid_q <= 2'b01 << owner_q;
                        rsp_rdata_q <= (pwrite_q || !bus.PREADY) ? '0 : bus.PRDATA;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign dbg_state_o   = state_q;
endmodule

// File: doc/apb_arb_master.md
# apb_arb_master

Two-port round-robin APB master that shares one APB bus, and the register slave behind it, between two internal requesters. It accepts a transfer from either requester through a valid/ready handshake and drives the SETUP/ACCESS phase sequence on PSEL/PENABLE. It honours PREADY wait states and returns read data with a per-requester response pulse. It sits between the processing logic and the APB register slave.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYC, 16, ACCESS cycles with PREADY low before abort (used only with APB_TIMEOUT_EN)

- PCLK  in  1  clock; all logic is on the rising edge
- PRESET  in  1  reset; one clock, synchronous, active-high
- req_valid  in  2  bit i: requester i has a transfer pending
- req_ready  out  2  bit i: one-cycle pulse when requester i's transfer is accepted
- req_write  in  2  bit i: 1 = write, 0 = read
- req_addr  in  2*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  requester i write data at [i*DATA_W +: DATA_W]
- rsp_valid  out  2  bit i: one-cycle completion pulse for requester i
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes
- rsp_err  out  1  valid with rsp_valid; 1 = aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB controls
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready; tie to 1 for a zero-wait-state slave

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any req_valid is set, pick a winner i (see arbitration).
  - In the same cycle, pulse req_ready[i] and latch req_write/addr/wdata[i] into PWRITE/PADDR/PWDATA.
  - Register the owner i. Go to SETUP.
- **SETUP:** PSEL=1, PENABLE=0. Go to ACCESS unconditionally.
- **ACCESS:** PSEL=1, PENABLE=1.
  - PREADY=1: the transfer completes. On a read, capture PRDATA into rsp_rdata; on a write, set rsp_rdata=0. Go to IDLE.
  - PREADY=0: stay in ACCESS.
- **Arbitration:** a last_grant register resets to 1.
  - Only one requester valid: it wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant updates on every acceptance.
- **Requester rules:** a requester holds req_valid and its payload stable until req_ready. The master does not re-sample a payload after acceptance.
- **Response:** rsp_valid[owner] pulses for one cycle, the cycle after completion. rsp_rdata and rsp_err hold their values until the next completion.
- **Bus hold:** PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS. They keep their last values in IDLE, while PSEL=0 and PENABLE=0.
- **Reset:** synchronous PRESET=1 forces IDLE.
  - All outputs go to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err.
  - last_grant goes to 1.
  - A transfer in flight is dropped and no rsp_valid is issued.

## Timing
- **Zero-wait transfer:** acceptance in cycle T (IDLE, req_ready), SETUP in T+1, ACCESS in T+2, rsp_valid in T+3.
  - The next acceptance can occur in T+3, so throughput is one transfer per 3 cycles.
- **Wait states:** each PREADY=0 cycle in ACCESS adds exactly one cycle of latency.
- **Simultaneous events:**
  - A req_valid that rises during SETUP or ACCESS waits for IDLE.
  - rsp_valid for one transfer and req_ready for the next may assert in the same cycle.
- **req_ready:** never asserted outside IDLE, and never on both bits at once.

## Configuration
- Macro: APB_TIMEOUT_EN.
- **Defined:**
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - If it reaches TIMEOUT_CYC with PREADY still 0, the transfer ends: go to IDLE, rsp_err=1, rsp_rdata=0, rsp_valid[owner] pulses the next cycle.
  - A PREADY=1 in that final cycle takes priority and completes normally with rsp_err=0.
- **Undefined:** the counter is absent, ACCESS waits indefinitely for PREADY, and rsp_err is tied to 0.

## Test plan
- Reset, then requester 0 writes 0xDEADBEEF to 0x4 with PREADY=1 → SETUP/ACCESS in T+1/T+2, rsp_valid[0] in T+3, rsp_rdata=0; a requester-0 read of 0x4 then returns 0xDEADBEEF.
- Both requesters read continuously (0x0 and 0x8) → grants alternate 0,1,0,1 starting with requester 0, and each rsp_valid matches its owner.
- Requester 1 reads 0xC while PREADY is held 0 for 3 ACCESS cycles → PSEL=1, PENABLE=1 and PADDR=0xC held stable, rsp_valid[1] in T+6.
- PRESET=1 during ACCESS of a requester-0 write → next cycle all outputs are 0 and no rsp_valid[0] occurs; the first post-reset grant goes to requester 0.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=4, PREADY held 0 → abort after 4 ACCESS wait cycles, rsp_err=1, rsp_rdata=0; the next transfer completes normally with rsp_err=0.
- Read of unmapped address 0x10 with PRDATA=0 → rsp_rdata=0, rsp_err=0, and the master returns to IDLE.
